// File: rtl/ps2_scan_sequencer.sv
// PS/2 Set-2 scan-code sequencer: synchronizes the receiver's done flag, folds E0/F0 prefixes
// into single key events and queues them in a FWFT FIFO. Optional macro: REPEAT_FILTER_EN.
module ps2_scan_sequencer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          CLK,
    input  logic                          rst,
    input  logic [7:0]                    rx_byte,
    input  logic                          rx_done,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [7:0]                    evt_code,
    output logic                          evt_ext,
    output logic                          evt_break,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          clr_overflow,
    output logic [1:0]                    o_dbg_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    // Handshake: an event transfers on a rising CLK edge where evt_valid && evt_ready;
    // evt_code/evt_ext/evt_break are the head entry and only change after a transfer.

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_stb;
    logic [7:0]             r_byte;
    state_t                 r_state;
    logic [9:0]             r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_wr;
    logic [AW-1:0]          r_rd;
    logic [CW-1:0]          r_count;
    logic                   r_ovf;

    logic w_is_e0, w_is_f0, w_err, w_prefix;
    logic w_push, w_ext, w_brk, w_accept;
    logic w_full, w_pop, w_wr, w_drop;

    // Strobe and captured byte are registered together so the decoder sees a stable byte.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_stb  <= 1'b0;
            r_byte <= 8'h00;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx_done};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_stb  <= r_sync[SYNC_STAGES-1] & ~r_prev;
            if (r_sync[SYNC_STAGES-1] & ~r_prev)
                r_byte <= rx_byte;
        end
    end

    assign w_is_e0  = (r_byte == 8'hE0);
    assign w_is_f0  = (r_byte == 8'hF0);
    assign w_err    = r_byte inside {8'h00, 8'hAA, 8'hE1, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
    assign w_prefix = w_is_e0 | w_is_f0;

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else if (r_stb) begin
            case (r_state)
                IDLE: begin
                    if (w_is_e0)      r_state <= EXT;
                    else if (w_is_f0) r_state <= BRK;
                end
                EXT: begin
                    if (w_is_f0)      r_state <= EXT_BRK;
                    else if (!w_is_e0) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_push = 1'b0;
        w_ext  = 1'b0;
        w_brk  = 1'b0;
        if (r_stb && !w_prefix && !w_err) begin
            w_push = 1'b1;
            w_ext  = (r_state == EXT) || (r_state == EXT_BRK);
            w_brk  = (r_state == BRK) || (r_state == EXT_BRK);
        end
    end

`ifdef REPEAT_FILTER_EN
    logic [7:0] r_held_code;
    logic       r_held_ext;
    logic       r_held_valid;
    logic       w_match;

    assign w_match  = r_held_valid && (r_held_code == r_byte) && (r_held_ext == w_ext);
    // Typematic repeats of the held key never reach the FIFO, so they cannot overflow it.
    assign w_accept = w_push && !(!w_brk && w_match);

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_held_code  <= 8'h00;
            r_held_ext   <= 1'b0;
            r_held_valid <= 1'b0;
        end else if (w_push) begin
            if (!w_brk) begin
                r_held_code  <= r_byte;
                r_held_ext   <= w_ext;
                r_held_valid <= 1'b1;
            end else if (w_match) begin
                r_held_valid <= 1'b0;
            end
        end
    end
`else
    assign w_accept = w_push;
`endif

    assign w_full = (r_count == FULL_CNT);
    assign w_pop  = evt_valid & evt_ready;
    // A pop frees the slot in the same cycle, so a push into a full FIFO is kept.
    assign w_wr   = w_accept & (~w_full | w_pop);
    assign w_drop = w_accept & w_full & ~w_pop;

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr] <= {w_brk, w_ext, r_byte};
                r_wr        <= r_wr + AW'(1);
            end
            if (w_pop)
                r_rd <= r_rd + AW'(1);
            if (w_wr && !w_pop)
                r_count <= r_count + CW'(1);
            else if (!w_wr && w_pop)
                r_count <= r_count - CW'(1);
            if (w_drop)
                r_ovf <= 1'b1;
            else if (clr_overflow)
                r_ovf <= 1'b0;
        end
    end

    assign evt_valid = (r_count != '0);
    assign {evt_break, evt_ext, evt_code} = evt_valid ? r_mem[r_rd] : 10'h000;
    assign fifo_count  = r_count;
    assign overflow    = r_ovf;
    assign o_dbg_state = r_state;

endmodule

// File: doc/ps2_scan_sequencer.md
Name: ps2_scan_sequencer

Overview:
Sits between the PS/2 byte receiver and the game logic. Takes raw scan-code bytes plus a done strobe, decodes the Set-2 prefix bytes (0xE0 extended, 0xF0 break) into single key events, and buffers those events in a small FIFO. Game logic reads events through a valid/ready handshake. Polling the receiver's byte output directly is no longer allowed.

Parameters:
FIFO_DEPTH, 4, event FIFO entries; must be a power of two, 2..16
SYNC_STAGES, 2, flip-flop stages synchronizing rx_done into CLK domain; minimum 2

Ports:
CLK  input  1  system clock (50 MHz)
rst  input  1  asynchronous, active-low reset
rx_byte  input  8  byte from PS/2 receiver; stable while rx_done is high
rx_done  input  1  receiver byte-complete flag; asynchronous to CLK; high for at least SYNC_STAGES+2 CLK cycles per byte
evt_valid  output  1  FIFO head holds an event
evt_ready  input  1  consumer accepts the head event this cycle
evt_code  output  8  scan code of the head event (prefixes stripped)
evt_ext  output  1  head event had the 0xE0 prefix
evt_break  output  1  head event is a key release (0xF0 seen)
fifo_count  output  $clog2(FIFO_DEPTH)+1  number of queued events
overflow  output  1  sticky; set when an event is dropped because the FIFO is full
clr_overflow  input  1  synchronous clear of overflow

Behaviour:
- Reset (rst=0, async) forces:
  - outputs: evt_valid=0, evt_code=0, evt_ext=0, evt_break=0, fifo_count=0, overflow=0
  - FSM=IDLE, synchronizer and edge-detect registers to 0
- rx_done passes through SYNC_STAGES flops, then a rising-edge detector. This yields a one-cycle byte_stb.
- rx_byte is captured into a register on byte_stb.
  - Latency: rx_done rising sampled at edge n -> byte_stb in cycle n+SYNC_STAGES -> event written at end of that cycle -> evt_valid=1 at n+SYNC_STAGES+1.
- Decoder FSM advances only on byte_stb; b = the captured byte:
  - IDLE: b=E0 -> EXT. b=F0 -> BRK. b in {00,AA,E1,FA,FC,FE,FF} -> discard, stay IDLE. Otherwise push {b,ext=0,brk=0}, stay IDLE.
  - EXT: b=F0 -> EXT_BRK. b=E0 -> stay EXT. Error/discard set as above -> IDLE, no push. Otherwise push {b,1,0} -> IDLE.
  - BRK: b=E0 or F0 -> IDLE, no push (protocol error). Error set -> IDLE. Otherwise push {b,0,1} -> IDLE.
  - EXT_BRK: any prefix or error byte -> IDLE, no push. Otherwise push {b,1,1} -> IDLE.
- FIFO behaviour:
  - First-word fall-through; evt_code/evt_ext/evt_break are driven from the head entry. They are undefined-but-stable when evt_valid=0; the implementation drives 0.
  - Pop occurs when evt_valid & evt_ready.
  - Push and pop in the same cycle: both happen and fifo_count is unchanged. This holds when full: the push is accepted, not dropped.
  - Push when full with no pop: event dropped, overflow<=1, count stays FIFO_DEPTH.
  - Pop when empty: ignored.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- overflow:
  - clr_overflow=1 clears it next edge.
  - A drop coinciding with clr_overflow wins: overflow stays 1.
- Reset mid-sequence (e.g. after E0) returns the FSM to IDLE; the next byte is decoded fresh.
- rx_done held high produces only one byte_stb; a new byte requires rx_done to fall and rise again.

Optional Feature:
Macro REPEAT_FILTER_EN:
- Defined:
  - Keeps a held-key register {code,ext,valid}, cleared on reset.
  - A make event matching the held key is suppressed: no push, no overflow effect. This filters typematic repeat.
  - A make event for a different key replaces the held register and is pushed.
  - A break event matching the held key clears valid. Every break event is pushed.
- Undefined: every decoded make event is pushed and no held-key register exists.

Test Plan:
- Byte 1C -> one event {code=1C, ext=0, brk=0}; evt_valid rises SYNC_STAGES+1 cycles after rx_done sampled high.
- Bytes E0,75 then E0,F0,75 -> events {75,1,0} then {75,1,1}; F0,1C -> {1C,0,1}.
- evt_ready=0, send 5 make codes 15,1D,24,2D,2C -> fifo_count=4, overflow=1. Pops yield 15,1D,24,2D. clr_overflow -> overflow=0.
- FIFO full, evt_ready=1 while byte 35 arrives -> count stays 4 and overflow stays 0. Head advances; 35 appears last.
- Send E0, assert rst for 1 cycle, then send 75 -> {75,0,0}. Bytes AA and FA -> no events. F0,E0 -> no event, FSM back in IDLE.
- Bytes 1C,1C,1C,F0,1C -> with REPEAT_FILTER_EN: 2 events (make 1C, break 1C). Without it: 4 events.
